// File: rtl/xdma_axis_pkg.sv
// Shared XDMA AXI-Stream widths and arbiter state type for the C2H/H2C stream glue.
package xdma_axis_pkg;

  localparam int XDMA_AXIS_TDATA_WIDTH = 512;
  localparam int XDMA_AXIS_TKEEP_WIDTH = 64;
  localparam int XDMA_AXIS_TUSER_WIDTH = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Modulo increment that also wraps correctly for non-power-of-two counts.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set req bit scanning ptr, ptr+1, ... modulo N.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/xdma_c2h_axis_arbiter.sv
// Packet-granular round-robin arbiter feeding the XDMA C2H AXI-Stream channel.
// Optional per-source packet counters are built when ARB_PKT_STATS_EN is defined.
module xdma_c2h_axis_arbiter
  import xdma_axis_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int TDATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = XDMA_AXIS_TUSER_WIDTH,
  localparam int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                           xdma_axi_aclk,
  input  logic                           xdma_axi_aresetn,

  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0] s_axis_tuser,

  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]         m_axis_tuser,

`ifdef ARB_PKT_STATS_EN
  input  logic                           pkt_cnt_clr,
  output logic [NUM_SRC*32-1:0]          pkt_cnt,
`endif

  output logic                           arb_busy,
  output logic [IDX_W-1:0]               arb_grant_idx
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             pkt_end;

  rr_select #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req   (s_axis_tvalid),
    .ptr   (rr_ptr_q),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign pkt_end = (state_q == ARB_BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
    if (!xdma_axi_aresetn) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          state_d = ARB_BUSY;
          grant_d = sel_idx;
        end
      end
      ARB_BUSY: begin
        if (pkt_end) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NUM_SRC));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    if (state_q == ARB_BUSY) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      m_axis_tdata           = s_axis_tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tkeep           = s_axis_tkeep[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
      m_axis_tuser           = s_axis_tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign arb_busy      = (state_q == ARB_BUSY);
  assign arb_grant_idx = grant_q;

`ifdef ARB_PKT_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_SRC];
  logic [31:0] pkt_cnt_d [NUM_SRC];

  // Clear takes priority over a coincident tlast increment.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (pkt_cnt_clr) begin
        pkt_cnt_d[i] = '0;
      end else if (pkt_end && (grant_q == IDX_W'(i))) begin
        pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  // NOTE: this array is a handful of flops, not a RAM, so every entry is reset.
  always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
    if (!xdma_axi_aresetn) begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_xdma_c2h_axis_arbiter.sv
// Self-checking bench for xdma_c2h_axis_arbiter (3 sources): table, directed packet sequences, random vs model.
module tb_xdma_c2h_axis_arbiter;
  import xdma_axis_pkg::*;

  localparam int NS = 3;
  localparam int DW = XDMA_AXIS_TDATA_WIDTH;
  localparam int KW = XDMA_AXIS_TKEEP_WIDTH;
  localparam int UW = XDMA_AXIS_TUSER_WIDTH;
  localparam int GW = $clog2(NS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0] sv = '0;
  logic [NS-1:0] sl = '0;
  logic          mr = 1'b0;
  logic [DW-1:0] sd [NS];
  logic [KW-1:0] sk [NS];
  logic [UW-1:0] su [NS];

  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS*UW-1:0] s_tuser;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid, m_tlast, busy;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic [GW-1:0]    gidx;
`ifdef ARB_PKT_STATS_EN
  logic             clr = 1'b0;
  logic [NS*32-1:0] pkt_cnt;
`endif

  always_comb begin
    s_tdata = '0;
    s_tkeep = '0;
    s_tuser = '0;
    for (int i = 0; i < NS; i++) begin
      s_tdata[i*DW +: DW] = sd[i];
      s_tkeep[i*KW +: KW] = sk[i];
      s_tuser[i*UW +: UW] = su[i];
    end
  end

  xdma_c2h_axis_arbiter #(.NUM_SRC(NS)) dut (
    .xdma_axi_aclk    (clk),
    .xdma_axi_aresetn (rst_n),
    .s_axis_tvalid    (sv),
    .s_axis_tready    (s_tready),
    .s_axis_tlast     (sl),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tuser     (s_tuser),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (mr),
    .m_axis_tlast     (m_tlast),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tuser     (m_tuser),
`ifdef ARB_PKT_STATS_EN
    .pkt_cnt_clr      (clr),
    .pkt_cnt          (pkt_cnt),
`endif
    .arb_busy         (busy),
    .arb_grant_idx    (gidx)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one grant owner, round-robin pointer, packet counters.
  bit          mdl_busy;
  int          mdl_g, mdl_ptr;
  logic [31:0] mcnt [NS];

  // Directed source behaviour: packets left, packet length, current beat.
  int            left [NS];
  int            len  [NS];
  int            b    [NS];
  int            drop_src  = -1;
  int            drop_beat = 0;
  bit            dropped   = 1'b0;
  logic [KW-1:0] last_keep = '1;

  int            grants [$];
  logic [DW-1:0] beats_d [$];
  logic [KW-1:0] beats_k [$];
  logic          beats_l [$];
  bit            busy_seen = 1'b0;

  typedef struct {
    logic [NS-1:0] sv, sl;
    logic          mr;
    logic          e_mv;
    logic [NS-1:0] e_sr;
    logic          e_ml, e_busy;
    logic [GW-1:0] e_grant;
    int            e_src;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_data(input int src, input int beat);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = {8'(src), 8'(beat), 16'(w)} ^ 32'hC3A5_0000;
    return d;
  endfunction

  function automatic bit any_left();
    for (int i = 0; i < NS; i++) if (left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdl_reset();
    mdl_busy = 1'b0;
    mdl_g    = 0;
    mdl_ptr  = 0;
    for (int i = 0; i < NS; i++) mcnt[i] = '0;
  endtask

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      if (left[i] > 0) begin
        sv[i] = 1'b1;
        sl[i] = (b[i] == len[i] - 1);
        sd[i] = make_data(i, b[i]);
        sk[i] = sl[i] ? last_keep : {KW{1'b1}};
        su[i] = UW'(b[i] & 1);
        if (i == drop_src && b[i] == drop_beat && !dropped) begin
          sv[i]   = 1'b0;
          dropped = 1'b1;
        end
      end else begin
        sv[i] = 1'b0;
        sl[i] = 1'b0;
        sd[i] = '0;
        sk[i] = '0;
        su[i] = '0;
      end
    end
  endtask

  // Called just after a falling edge with inputs applied: compare, update model, wait one cycle.
  task automatic tick();
    logic [NS-1:0]    e_sr;
    logic             e_mv, e_ml;
    logic [DW-1:0]    e_d;
    logic [KW-1:0]    e_k;
    logic [UW-1:0]    e_u;
    logic [NS*32-1:0] e_cnt;
    bit               acc;
    #1;
    if (!rst_n) mdl_reset();
    e_sr = '0; e_mv = 1'b0; e_ml = 1'b0; e_d = '0; e_k = '0; e_u = '0;
    if (mdl_busy) begin
      e_mv        = sv[mdl_g];
      e_ml        = sl[mdl_g];
      e_d         = sd[mdl_g];
      e_k         = sk[mdl_g];
      e_u         = su[mdl_g];
      e_sr[mdl_g] = mr;
    end
    check("ctrl", 640'({m_tvalid, s_tready, m_tlast, busy, gidx}),
                  640'({e_mv, e_sr, e_ml, mdl_busy, GW'(mdl_g)}));
    check("payload", 640'({m_tdata, m_tkeep, m_tuser}), 640'({e_d, e_k, e_u}));
    e_cnt = '0;
    for (int i = 0; i < NS; i++) e_cnt[i*32 +: 32] = mcnt[i];
`ifdef ARB_PKT_STATS_EN
    check("pkt_cnt", 640'(pkt_cnt), 640'(e_cnt));
`endif
    if (busy && !busy_seen) grants.push_back(int'(gidx));
    busy_seen = busy;
    if (m_tvalid && mr) begin
      beats_d.push_back(m_tdata);
      beats_k.push_back(m_tkeep);
      beats_l.push_back(m_tlast);
    end
    acc = rst_n && mdl_busy && sv[mdl_g] && mr;
    if (acc && left[mdl_g] > 0) begin
      if (sl[mdl_g]) begin
        b[mdl_g] = 0;
        left[mdl_g]--;
      end else begin
        b[mdl_g]++;
      end
    end
`ifdef ARB_PKT_STATS_EN
    if (clr) begin
      for (int i = 0; i < NS; i++) mcnt[i] = '0;
    end else if (acc && sl[mdl_g]) begin
      mcnt[mdl_g] = mcnt[mdl_g] + 32'd1;
    end
`endif
    if (rst_n) begin
      if (!mdl_busy) begin
        for (int k = 0; k < NS; k++) begin
          int c = (mdl_ptr + k) % NS;
          if (sv[c]) begin
            mdl_busy = 1'b1;
            mdl_g    = c;
            break;
          end
        end
      end else if (acc && sl[mdl_g]) begin
        mdl_busy = 1'b0;
        mdl_ptr  = (mdl_g + 1) % NS;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_pkts(input string tag, input int max_cyc, input bit toggle);
    int c = 0;
    while ((any_left() || mdl_busy) && c < max_cyc) begin
      drive_src();
      mr = toggle ? (c % 2 == 0) : 1'b1;
      tick();
      c++;
    end
    check({tag, "_in_budget"}, 640'(c < max_cyc), 640'(1));
    drive_src();
  endtask

  task automatic check_grants(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_npkts"}, 640'(grants.size()), 640'(n));
    for (int i = 0; i < n && i < grants.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), 640'(grants[i]), 640'(e[i]));
  endtask

  initial begin
    tbl[0] = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, -1};
    tbl[1] = '{3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 2'd0,  0};
    tbl[2] = '{3'b011, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 2'd0,  0};
    tbl[3] = '{3'b001, 3'b001, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 2'd0,  0};
    tbl[4] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, -1};
    tbl[5] = '{3'b011, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, -1};
    tbl[6] = '{3'b011, 3'b010, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 2'd1,  1};
    tbl[7] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, -1};

    for (int i = 0; i < NS; i++) begin
      left[i] = 0; len[i] = 1; b[i] = 0;
      sd[i] = '0; sk[i] = '0; su[i] = '0;
    end
    mdl_reset();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // Table: src0 3-beat packet, src1 ignored while busy, then pointer moves to src1.
    for (int r = 0; r < 8; r++) begin
      logic [DW+KW+UW-1:0] e_pay;
      sv = tbl[r].sv; sl = tbl[r].sl; mr = tbl[r].mr;
      for (int i = 0; i < NS; i++) begin
        sd[i] = make_data(i, 0); sk[i] = {KW{1'b1}}; su[i] = '0;
      end
      #1;
      check($sformatf("tbl%0d_ctrl", r), 640'({m_tvalid, s_tready, m_tlast, busy, gidx}),
            640'({tbl[r].e_mv, tbl[r].e_sr, tbl[r].e_ml, tbl[r].e_busy, tbl[r].e_grant}));
      e_pay = (tbl[r].e_src < 0) ? '0 : {make_data(tbl[r].e_src, 0), {KW{1'b1}}, {UW{1'b0}}};
      check($sformatf("tbl%0d_payload", r), 640'({m_tdata, m_tkeep, m_tuser}), 640'(e_pay));
      tick();
    end

    // Two sources, continuous valid, 2-beat packets: strict alternation.
    grants.delete();
    left = '{2, 2, 0}; len = '{2, 2, 1};
    run_pkts("alt", 60, 1'b0);
    check_grants("alt", 4, 0, 1, 0, 1);

    // Src1 4 beats, downstream ready toggling, valid dropped on the second beat.
    grants.delete(); beats_d.delete(); beats_k.delete(); beats_l.delete();
    left = '{0, 1, 0}; len = '{1, 4, 1};
    drop_src = 1; drop_beat = 1; dropped = 1'b0;
    last_keep = 64'h0000_0000_0000_FFFF;
    run_pkts("stall", 60, 1'b1);
    drop_src = -1; last_keep = '1;
    check_grants("stall", 1, 1, 0, 0, 0);
    check("stall_nbeats", 640'(beats_d.size()), 640'(4));
    for (int i = 0; i < 4 && i < beats_d.size(); i++) begin
      check($sformatf("stall_data%0d", i), 640'(beats_d[i]), 640'(make_data(1, i)));
      check($sformatf("stall_last%0d", i), 640'(beats_l[i]), 640'(i == 3));
    end
    if (beats_k.size() == 4) check("stall_keep_last", 640'(beats_k[3]), 640'(64'h0000_0000_0000_FFFF));

    // All three requesting from pointer 2: wrap 2 -> 0 on a non-power-of-two count.
    grants.delete();
    left = '{1, 1, 2}; len = '{1, 1, 1};
    run_pkts("wrap", 60, 1'b0);
    check_grants("wrap", 4, 2, 0, 1, 2);

    // Asynchronous reset in the middle of a 5-beat packet from src1.
    begin
      int c = 0;
      left = '{0, 1, 0}; len = '{1, 5, 1};
      while (b[1] < 2 && c < 40) begin
        drive_src(); mr = 1'b1; tick(); c++;
      end
      check("rst_reach_beat2", 640'(b[1]), 640'(2));
      drive_src();
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_ctrl", 640'({m_tvalid, s_tready, busy, gidx}), 640'(0));
      check("rst_async_payload", 640'({m_tdata, m_tkeep, m_tuser}), 640'(0));
      mdl_reset();
      for (int i = 0; i < NS; i++) begin left[i] = 0; b[i] = 0; end
      drive_src();
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      grants.delete();
      left = '{1, 1, 1}; len = '{1, 1, 1};
      run_pkts("post_rst", 40, 1'b0);
      check_grants("post_rst", 3, 0, 1, 2, 0);
    end

`ifdef ARB_PKT_STATS_EN
    // Packet counters: 5 from src0, 2 from src1 after a clear; then clear coinciding with tlast.
    clr = 1'b1; tick(); clr = 1'b0;
    left = '{5, 2, 0}; len = '{1, 1, 1};
    run_pkts("stats", 80, 1'b0);
    tick();
    check("stats_cnt", 640'(pkt_cnt), 640'({32'd0, 32'd2, 32'd5}));
    clr = 1'b1;
    left = '{1, 0, 0};
    run_pkts("stats_clr", 20, 1'b0);
    clr = 1'b0;
    tick();
    check("stats_clr_wins", 640'(pkt_cnt), 640'(0));
`endif

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NS; i++) begin
        for (int w = 0; w < DW/32; w++) sd[i][w*32 +: 32] = $urandom;
        sk[i] = {$urandom, $urandom};
        su[i] = UW'($urandom_range(1));
      end
      sv = NS'($urandom);
      sl = NS'($urandom & $urandom);
      mr = ($urandom_range(3) != 0);
`ifdef ARB_PKT_STATS_EN
      clr = ($urandom_range(15) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
